// File: rtl/spi_mem_pkg.sv
// SPI RAM opcodes, frame geometry and controller state encoding shared by the arbiter and shift engine.
package spi_mem_pkg;
   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam int         FRAME_W  = 32;
   localparam int         HALF_W   = 6;   // counts the 64 SCK half-periods of one frame

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_DONE
   } state_t;
endpackage

// File: rtl/spi_shift_engine.sv
// SCK divider, 32-bit MSB-first transmit register and 8-bit receive register for SPI mode 0.
// A frame takes 64*CLK_DIV cycles of i_run. The engine has no backpressure and follows the arbiter FSM.
module spi_shift_engine
   import spi_mem_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic [FRAME_W-1:0] i_frame,
   input  logic               i_cnt_en,
   input  logic               i_run,
   input  logic               i_miso,
   output logic               o_tick,
   output logic               o_last,
   output logic               o_sck,
   output logic               o_mosi,
   output logic [7:0]         o_rx
);
   logic [3:0]         r_div;
   logic [HALF_W-1:0]  r_half;
   logic               r_sck;
   logic [FRAME_W-1:0] r_tx;
   logic [7:0]         r_rx;
   logic               w_tick;

   assign w_tick = (r_div == 4'(CLK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div  <= '0;
         r_half <= '0;
         r_sck  <= 1'b0;
         r_tx   <= '0;
         r_rx   <= '0;
      end else if (i_load) begin
         r_div  <= '0;
         r_half <= '0;
         r_sck  <= 1'b0;
         r_tx   <= i_frame;
      end else begin
         if (i_cnt_en)
            r_div <= w_tick ? '0 : r_div + 4'd1;
         // Rising SCK samples MISO; falling SCK advances MOSI to the next bit.
         if (i_run && w_tick) begin
            r_half <= r_half + HALF_W'(1);
            r_sck  <= ~r_sck;
            if (!r_sck)
               r_rx <= {r_rx[6:0], i_miso};
            else
               r_tx <= {r_tx[FRAME_W-2:0], 1'b0};
         end
      end
   end

   assign o_tick = w_tick;
   assign o_last = i_run && w_tick && (r_half == {HALF_W{1'b1}});
   assign o_sck  = r_sck;
   assign o_mosi = r_tx[FRAME_W-1];
   assign o_rx   = r_rx;
endmodule

// File: rtl/spi_mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one SPI RAM, round-robin on ties. A frame is 32 bits.
// Ack comes 66*CLK_DIV cycles after the grant. Requests are sampled only in IDLE, and a waiting port holds req.
module spi_mem_arbiter
   import spi_mem_pkg::*;
#(
   parameter int CLK_DIV = 1,
   parameter int ADDR_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [7:0]        d_wdata,
   output logic              d_ack,
   output logic [7:0]        rdata,
   output logic              busy,
   output logic              spi_cs_n,
   output logic              spi_sck,
   output logic              spi_mosi,
   input  logic              spi_miso
);
   state_t             r_state, w_next;
   logic               r_gnt_d, r_ptr_d, r_we;
   logic [7:0]         r_rdata;
   logic               w_load, w_gnt_d, w_tick, w_last;
   logic [15:0]        w_addr16;
   logic [FRAME_W-1:0] w_frame;
   logic [7:0]         w_rx;

   // r_ptr_d set means the data port wins the next tie.
   assign w_gnt_d = d_req && (!f_req || r_ptr_d);

   always_comb begin
      w_addr16 = '0;
      if (w_gnt_d)
         w_addr16[ADDR_W-1:0] = d_addr;
      else
         w_addr16[ADDR_W-1:0] = f_addr;
      w_frame = {OP_READ, w_addr16, 8'h00};
      if (w_gnt_d && d_we)
         w_frame = {OP_WRITE, w_addr16, d_wdata};
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      case (r_state)
         ST_IDLE:  if (f_req || d_req) begin
                      w_next = ST_SETUP;
                      w_load = 1'b1;
                   end
         ST_SETUP: if (w_tick) w_next = ST_SHIFT;
         ST_SHIFT: if (w_last) w_next = ST_HOLD;
         ST_HOLD:  if (w_tick) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_gnt_d <= 1'b0;
         r_ptr_d <= 1'b0;
         r_we    <= 1'b0;
         r_rdata <= 8'h00;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_gnt_d <= w_gnt_d;
            r_ptr_d <= ~w_gnt_d;
            r_we    <= w_gnt_d && d_we;
         end
         if (r_state == ST_HOLD && w_tick && !r_we)
            r_rdata <= w_rx;
      end
   end

   spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .i_frame  (w_frame),
      .i_cnt_en (r_state == ST_SETUP || r_state == ST_SHIFT || r_state == ST_HOLD),
      .i_run    (r_state == ST_SHIFT),
      .i_miso   (spi_miso),
      .o_tick   (w_tick),
      .o_last   (w_last),
      .o_sck    (spi_sck),
      .o_mosi   (spi_mosi),
      .o_rx     (w_rx)
   );

   assign f_ack    = (r_state == ST_DONE) && !r_gnt_d;
   assign d_ack    = (r_state == ST_DONE) && r_gnt_d;
   assign rdata    = r_rdata;
   assign busy     = (r_state != ST_IDLE);
   assign spi_cs_n = !(r_state == ST_SETUP || r_state == ST_SHIFT || r_state == ST_HOLD);
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Two arbiters (CLK_DIV 1 and 3), each attached to a behavioural 256-byte SPI RAM.
// The checks compare the DUT against a memory/round-robin reference model.
module tb_spi_mem_arbiter;
   logic             clk, rst;
   logic [1:0]       f_req, d_req, d_we;
   logic [1:0][15:0] f_addr, d_addr;
   logic [1:0][7:0]  d_wdata, rdata;
   logic [1:0]       f_ack, d_ack, busy, cs_n, sck, mosi;
   int               checks = 0;
   int               errors = 0;
   logic [7:0]       model [2][256];
   logic [7:0]       last_rd [2];

   function automatic logic [7:0] ram_init(input int a);
      case (a)
         0:       return 8'h11;
         4:       return 8'h63;
         default: return 8'(a * 37 + 5);
      endcase
   endfunction

   function automatic int div_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int DIV = (g == 0) ? 1 : 3;
      logic        so;
      logic [31:0] cap;
      logic [7:0]  ram [256];

      spi_mem_arbiter #(.CLK_DIV(DIV), .ADDR_W(16)) u_dut (
         .clk(clk), .rst(rst),
         .f_req(f_req[g]), .f_addr(f_addr[g]), .f_ack(f_ack[g]),
         .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]), .d_ack(d_ack[g]),
         .rdata(rdata[g]), .busy(busy[g]),
         .spi_cs_n(cs_n[g]), .spi_sck(sck[g]), .spi_mosi(mosi[g]), .spi_miso(so)
      );

      // Mode-0 RAM: captures MOSI on rising SCK and drives the read byte after each falling SCK.
      initial begin : slave
         logic       ps, pc;
         logic [7:0] b, ab;
         int         nbits;
         for (int k = 0; k < 256; k++) ram[k] = ram_init(k);
         so = 1'b0; cap = '0; nbits = 0; ps = 1'b0; pc = 1'b1; ab = '0;
         forever begin
            @(sck[g] or cs_n[g]);
            if (cs_n[g] !== pc) begin
               pc = cs_n[g];
               if (!pc) begin nbits = 0; cap = '0; end
            end
            if (sck[g] !== ps) begin
               ps = sck[g];
               if (!pc && ps) begin
                  cap = {cap[30:0], mosi[g]};
                  nbits++;
                  if (nbits == 24) ab = cap[7:0];
                  if (nbits == 32 && cap[31:24] == 8'h02) ram[cap[15:8]] = cap[7:0];
               end else if (!pc && !ps && nbits >= 24 && nbits < 32) begin
                  b = ram[ab];
                  so = b[31 - nbits];
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits for an ack on instance i. It counts cycles and also checks the SCK timing and the MOSI update points.
   task automatic run_txn(input int i, input int limit, input int chg_at, output int cnt,
                          output logic [1:0] acks, output logic [7:0] rd,
                          output int nchg, output int badgap, output int badmosi);
      logic ps, pm, pc;
      int   last;
      cnt = 0; acks = '0; rd = '0; nchg = 0; badgap = 0; badmosi = 0; last = -1;
      ps = sck[i]; pm = mosi[i]; pc = cs_n[i];
      while (cnt < limit) begin
         @(posedge clk); #1;
         cnt++;
         if (chg_at != 0 && cnt == chg_at) begin
            f_addr[i] = ~f_addr[i]; d_addr[i] = ~d_addr[i];
            d_wdata[i] = ~d_wdata[i]; d_we[i] = ~d_we[i];
         end
         if (sck[i] !== ps) begin
            nchg++;
            if (last >= 0 && cnt - last != div_of(i)) badgap++;
            last = cnt;
         end
         if (mosi[i] !== pm && !pc && !(ps && !sck[i])) badmosi++;
         ps = sck[i]; pm = mosi[i]; pc = cs_n[i];
         if (f_ack[i] || d_ack[i]) begin
            acks = {d_ack[i], f_ack[i]};
            rd = rdata[i];
            break;
         end
      end
   endtask

   task automatic xact(input int i, input bit dp, input bit we, input logic [15:0] a,
                       input logic [7:0] wd, input int chg_at, input string tag);
      int          cnt, nchg, bg, bm;
      logic [1:0]  acks;
      logic [7:0]  rd, exp_rd;
      logic [31:0] fr, ef;
      bit          wr;
      wr = dp && we;
      f_addr[i] = a; d_addr[i] = a; d_wdata[i] = wd; d_we[i] = we;
      if (dp) d_req[i] = 1'b1; else f_req[i] = 1'b1;
      run_txn(i, 2000, chg_at, cnt, acks, rd, nchg, bg, bm);
      f_req[i] = 1'b0; d_req[i] = 1'b0;
      fr = (i == 0) ? g_dut[0].cap : g_dut[1].cap;
      exp_rd = wr ? last_rd[i] : model[i][a[7:0]];
      ef = {(wr ? 8'h02 : 8'h03), a, (wr ? wd : 8'h00)};
      check({tag, " latency"}, cnt, 66 * div_of(i) + 1);
      check({tag, " ack"}, 32'(acks), dp ? 32'h2 : 32'h1);
      check({tag, " rdata"}, 32'(rd), 32'(exp_rd));
      check({tag, " frame"}, fr, ef);
      check({tag, " sck edges"}, nchg, 64);
      check({tag, " sck half-period"}, bg, 0);
      check({tag, " mosi timing"}, bm, 0);
      if (wr) model[i][a[7:0]] = wd; else last_rd[i] = exp_rd;
      @(posedge clk); #1;
      check({tag, " idle busy"}, 32'(busy[i]), 0);
      check({tag, " idle acks"}, 32'({d_ack[i], f_ack[i]}), 0);
   endtask

   initial begin
      int         cnt, nchg, bg, bm, rises, nack;
      logic [1:0] acks;
      logic [7:0] rd;
      logic [15:0] ra;
      logic [31:0] fr;
      logic       ps;
      bit         exp_f, dp, we;
      rst = 1'b1; f_req = '0; d_req = '0; d_we = '0;
      f_addr = '0; d_addr = '0; d_wdata = '0;
      for (int i = 0; i < 2; i++) begin
         last_rd[i] = 8'h00;
         for (int k = 0; k < 256; k++) model[i][k] = ram_init(k);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset cs_n%0d", i), 32'(cs_n[i]), 1);
         check($sformatf("reset sck/mosi%0d", i), 32'({sck[i], mosi[i]}), 0);
         check($sformatf("reset acks/busy%0d", i), 32'({f_ack[i], d_ack[i], busy[i]}), 0);
         check($sformatf("reset rdata%0d", i), 32'(rdata[i]), 0);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Both ports requesting from reset: fetch wins the first tie, then the grants alternate.
      f_addr[0] = 16'h0004; d_addr[0] = 16'h0020; d_we[0] = 1'b0;
      f_req[0] = 1'b1; d_req[0] = 1'b1;
      exp_f = 1'b1;
      for (int t = 0; t < 4; t++) begin
         run_txn(0, 2000, 0, cnt, acks, rd, nchg, bg, bm);
         check($sformatf("rr%0d ack", t), 32'(acks), exp_f ? 32'h1 : 32'h2);
         check($sformatf("rr%0d latency", t), cnt, (t == 0) ? 67 : 68);
         check($sformatf("rr%0d rdata", t), 32'(rd), 32'(model[0][exp_f ? 8'h04 : 8'h20]));
         last_rd[0] = model[0][exp_f ? 8'h04 : 8'h20];
         exp_f = !exp_f;
      end
      f_req[0] = 1'b0; d_req[0] = 1'b0;
      @(posedge clk); #1;

      xact(0, 1'b0, 1'b0, 16'h0000, 8'h00, 0, "fetch0");
      xact(0, 1'b1, 1'b1, 16'h0010, 8'hA5, 0, "write10");
      xact(0, 1'b1, 1'b0, 16'h0010, 8'h00, 0, "read10");

      // Back-to-back fetches with f_req held. The address changes in flight and must not reach the current frame.
      f_addr[0] = 16'h0004; f_req[0] = 1'b1;
      run_txn(0, 2000, 10, cnt, acks, rd, nchg, bg, bm);
      check("b2b first latency", cnt, 67);
      check("b2b first ack", 32'(acks), 32'h1);
      check("b2b first rdata", 32'(rd), 32'(model[0][8'h04]));
      check("b2b first frame", g_dut[0].cap, 32'h03000400);
      @(posedge clk); #1;
      check("b2b idle cs_n", 32'({cs_n[0], busy[0]}), 32'h2);
      @(posedge clk); #1;
      check("b2b setup cs_n", 32'(cs_n[0]), 0);
      run_txn(0, 2000, 0, cnt, acks, rd, nchg, bg, bm);
      f_req[0] = 1'b0;
      check("b2b second latency", cnt, 66);
      check("b2b second rdata", 32'(rd), 32'(model[0][8'hFB]));
      check("b2b second frame", g_dut[0].cap, 32'h03FFFB00);
      check("b2b second sck edges", nchg, 64);
      last_rd[0] = model[0][8'hFB];
      @(posedge clk); #1;

      for (int t = 0; t < 6; t++) begin
         dp = 1'($urandom_range(0, 1));
         we = dp ? 1'($urandom_range(0, 1)) : 1'b0;
         ra = {8'($urandom()), 8'h40 + 8'($urandom_range(0, 3))};
         xact(0, dp, we, ra, 8'($urandom()), (t % 2 == 1) ? 15 : 0, $sformatf("rnd%0d", t));
      end

      // Reset at the 20th SCK rising edge of a fetch aborts the frame without an ack.
      f_addr[0] = 16'h0004; f_req[0] = 1'b1;
      rises = 0; cnt = 0; ps = sck[0];
      while (rises < 20 && cnt < 2000) begin
         @(posedge clk); #1;
         cnt++;
         if (sck[0] && !ps) rises++;
         ps = sck[0];
      end
      check("abort reached edge 20", rises, 20);
      rst = 1'b1;
      #1;
      check("abort cs_n", 32'(cs_n[0]), 1);
      check("abort ack/busy/sck/mosi", 32'({f_ack[0], d_ack[0], busy[0], sck[0], mosi[0]}), 0);
      check("abort rdata", 32'(rdata[0]), 0);
      f_req[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      last_rd[0] = 8'h00; last_rd[1] = 8'h00;
      nack = 0;
      repeat (200) begin
         @(posedge clk); #1;
         if (f_ack[0] || d_ack[0] || busy[0]) nack++;
      end
      check("abort no ack", nack, 0);
      xact(0, 1'b0, 1'b0, 16'h0004, 8'h00, 0, "post-reset fetch");

      xact(1, 1'b0, 1'b0, 16'h0004, 8'h00, 0, "div3 fetch");
      xact(1, 1'b1, 1'b1, 16'h0123, 8'h5C, 0, "div3 write");
      xact(1, 1'b1, 1'b0, 16'h0123, 8'h00, 40, "div3 read");
      fr = g_dut[1].cap;
      check("div3 read frame addr kept", fr[23:8], 32'h0123);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
